// File: rtl/qracc_mac_scheduler.sv
// Batch sequencer for seq_acc: fetches activation vectors, issues them over valid/ready,
// and writes every MAC result to consecutive result-buffer addresses.
module qracc_mac_scheduler #(
  parameter int unsigned inputBits       = 5,
  parameter int unsigned inputElements   = 128,
  parameter int unsigned outputElements  = 32,
  parameter int unsigned accumulatorBits = 16,
  parameter int unsigned addrBits        = 10
) (
  input  logic                                       clk,
  input  logic                                       nrst,
  input  logic                                       start_i,
  input  logic [addrBits-1:0]                        num_vec_i,
  input  logic [addrBits-1:0]                        rd_base_i,
  input  logic [addrBits-1:0]                        wr_base_i,
  output logic                                       busy_o,
  output logic                                       done_o,
  output logic                                       err_o,
  output logic                                       act_rd_en_o,
  output logic [addrBits-1:0]                        act_rd_addr_o,
  input  logic [inputElements*inputBits-1:0]         act_rd_data_i,
  output logic [inputElements*inputBits-1:0]         mac_data_o,
  output logic                                       mac_valid_o,
  input  logic                                       mac_ready_i,
  input  logic                                       mac_res_valid_i,
  input  logic [outputElements*accumulatorBits-1:0]  mac_res_data_i,
  output logic                                       res_wr_en_o,
  output logic [addrBits-1:0]                        res_wr_addr_o,
  output logic [outputElements*accumulatorBits-1:0]  res_wr_data_o
);

  localparam int unsigned ActW = inputElements * inputBits;
  localparam int unsigned ResW = outputElements * accumulatorBits;

  typedef enum logic [2:0] {StIdle, StFetch, StLoad, StIssue, StDrain, StDone} state_e;

  state_e              state_q, state_d;
  logic [addrBits-1:0] num_q, rd_base_q, wr_base_q;
  logic [addrBits-1:0] issued_q, done_cnt_q;
  logic [ActW-1:0]     issue_q;
  logic                wr_en_q, err_q;
  logic [addrBits-1:0] wr_addr_q;
  logic [ResW-1:0]     wr_data_q;

  logic                capture_active, res_expected, accept;
  logic [addrBits:0]   issued_next;

  assign capture_active = state_q inside {StFetch, StLoad, StIssue, StDrain};
  assign res_expected   = capture_active && (done_cnt_q != num_q);
  assign accept         = (state_q == StIssue) && mac_ready_i;
  // One bit wider so the last-vector compare cannot wrap.
  assign issued_next    = {1'b0, issued_q} + (addrBits + 1)'(1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start_i) state_d = (num_vec_i == '0) ? StDone : StFetch;
      StFetch: state_d = StLoad;
      StLoad:  state_d = StIssue;
      StIssue: begin
        if (mac_ready_i) state_d = (issued_next < {1'b0, num_q}) ? StFetch : StDrain;
      end
      StDrain: if ((done_cnt_q == num_q) && !wr_en_q) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q    <= StIdle;
      num_q      <= '0;
      rd_base_q  <= '0;
      wr_base_q  <= '0;
      issued_q   <= '0;
      done_cnt_q <= '0;
      issue_q    <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_en_q <= 1'b0;
      if ((state_q == StIdle) && start_i) begin
        num_q      <= num_vec_i;
        rd_base_q  <= rd_base_i;
        wr_base_q  <= wr_base_i;
        issued_q   <= '0;
        done_cnt_q <= '0;
        err_q      <= 1'b0;
      end
      if (state_q == StLoad) issue_q <= act_rd_data_i;
      if (accept) issued_q <= issued_q + addrBits'(1);
      // Results cannot be stalled: capture whenever one is expected, flag it otherwise.
      if (mac_res_valid_i) begin
        if (res_expected) begin
          wr_en_q    <= 1'b1;
          wr_addr_q  <= wr_base_q + done_cnt_q;
          wr_data_q  <= mac_res_data_i;
          done_cnt_q <= done_cnt_q + addrBits'(1);
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign busy_o        = (state_q != StIdle);
  assign done_o        = (state_q == StDone);
  assign err_o         = err_q;
  assign act_rd_en_o   = (state_q == StFetch);
  assign act_rd_addr_o = act_rd_en_o ? (rd_base_q + issued_q) : '0;
  assign mac_valid_o   = (state_q == StIssue);
  assign mac_data_o    = issue_q;
  assign res_wr_en_o   = wr_en_q;
  assign res_wr_addr_o = wr_addr_q;
  assign res_wr_data_o = wr_data_q;

endmodule
